// File: rtl/arb_pkg.sv
// Shared constants and FSM encoding for the four-channel round-robin drain stage.
package arb_pkg;

    localparam int N_CH = 4;
    localparam int CH_W = 2;

    // Grant pointer value after reset: the search starts at last+1, so channel 0 goes first.
    localparam logic [CH_W-1:0] LAST_RST = 2'd3;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: grants the first requester after 'last'.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_CH-1:0] request,
    input  logic [CH_W-1:0] last,
    output logic [N_CH-1:0] grant,
    output logic [CH_W-1:0] grant_idx
);

    logic [CH_W-1:0] idx;
    logic            found;

    // Walk last+1, last+2, ... last+4 (wrapping) and take the first requester.
    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = last + CH_W'(k);
            if (!found && request[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain of four upstream FIFOs into one downstream FIFO, with
// single-word-in-flight back-pressure and a sticky upstream-error state.
module fifo_rr_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   fifo_empty,
    input  logic [N_CH-1:0]   fifo_error,
    input  logic [DATA_W-1:0] fifo_data0,
    input  logic [DATA_W-1:0] fifo_data1,
    input  logic [DATA_W-1:0] fifo_data2,
    input  logic [DATA_W-1:0] fifo_data3,
    input  logic              out_full,
    input  logic              out_almost_full,
    output logic [N_CH-1:0]   pop,
    output logic              push,
    output logic [DATA_W-1:0] data_out,
    output logic [CH_W-1:0]   active_ch,
    output logic              idle,
    output logic              error
);

    state_t          state;
    state_t          state_next;
    logic [CH_W-1:0] last;
    logic [N_CH-1:0] grant;
    logic [CH_W-1:0] grant_idx;
    logic            stall;

    rr_pick u_pick (
        .request   (~fifo_empty),
        .last      (last),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Either downstream flag stops new pops; one word in flight always fits.
    assign stall = out_full | out_almost_full;

    // FSM state register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: RESET -> RUN on release, RUN -> ERROR on any upstream error.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_RESET: state_next = ST_RUN;
            ST_RUN:   if (|fifo_error) state_next = ST_ERROR;
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_RESET;
        endcase
    end

    // Pop decision: only in RUN, not stalled, and cut off in the cycle an error shows up.
    always_comb begin
        pop = '0;
        if (state == ST_RUN && !stall && !(|fifo_error)) begin
            pop = grant;
        end
    end

    // Forwarding registers: push follows pop by one cycle; pointer and channel track the grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last      <= LAST_RST;
            push      <= 1'b0;
            active_ch <= '0;
        end else begin
            push <= |pop;
            if (|pop) begin
                last      <= grant_idx;
                active_ch <= grant_idx;
            end
        end
    end

    // Output data mux; held at zero whenever no word is being written downstream.
    always_comb begin
        data_out = '0;
        if (push) begin
            unique case (active_ch)
                2'd0: data_out = fifo_data0;
                2'd1: data_out = fifo_data1;
                2'd2: data_out = fifo_data2;
                2'd3: data_out = fifo_data3;
                default: data_out = '0;
            endcase
        end
    end

    assign idle  = (state == ST_RUN) && (&fifo_empty) && !push;
    assign error = (state == ST_ERROR);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Scoreboard bench for fifo_rr_arbiter with behavioural upstream/downstream FIFO models.
module tb_fifo_rr_arbiter;

    localparam int DW = 10;

    typedef struct {
        int          ch;
        logic [DW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    pop;
    logic          push;
    logic [DW-1:0] data_out;
    logic [1:0]    active_ch;
    logic          idle;
    logic          error;

    // Upstream FIFO models: queues, registered read data, empty/underflow flags.
    logic [DW-1:0] up_q [4][$];
    logic [DW-1:0] up_data [4] = '{default: '0};
    logic [3:0]    up_empty = 4'hF;
    logic [3:0]    up_err = 4'h0;
    logic [3:0]    err_force = 4'h0;
    logic          clr_req = 1'b0;
    word_t         stage[$];
    word_t         stg_w;

    // Downstream FIFO model: depth 8, either draining or never read.
    int            ds_count = 0;
    logic          ds_ovf = 1'b0;
    logic          ds_drain = 1'b1;
    logic          ds_clr = 1'b0;
    logic          af_force = 1'b0;
    logic          out_full;
    logic          out_almost_full;

    word_t         sb[$];
    word_t         mon_w;
    int            n_cmp = 0;
    int            n_bad = 0;

    assign out_full        = (ds_count >= 8);
    assign out_almost_full = (ds_count >= 7) || af_force;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.DATA_W(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty      (up_empty),
        .fifo_error      (up_err | err_force),
        .fifo_data0      (up_data[0]),
        .fifo_data1      (up_data[1]),
        .fifo_data2      (up_data[2]),
        .fifo_data3      (up_data[3]),
        .out_full        (out_full),
        .out_almost_full (out_almost_full),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .active_ch       (active_ch),
        .idle            (idle),
        .error           (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic stage_word(input int ch, input logic [DW-1:0] v);
        word_t w;
        w.ch = ch;
        w.data = v;
        stage.push_back(w);
    endtask

    task automatic expect_word(input int ch, input logic [DW-1:0] v);
        word_t w;
        w.ch = ch;
        w.data = v;
        sb.push_back(w);
    endtask

    // Waits until the monitor has consumed every expected word, bounded by a cycle budget.
    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d words still pending, required 0", name, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #2;
    endtask

    // Upstream model: read data registers at the pop edge, empty updates after the edge.
    always @(posedge clk) begin
        if (clr_req) begin
            for (int i = 0; i < 4; i++) up_q[i].delete();
            stage.delete();
            up_err   <= '0;
            up_empty <= '1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pop[i]) begin
                    if (up_q[i].size() == 0) up_err[i] <= 1'b1;
                    else up_data[i] <= up_q[i].pop_front();
                end
            end
            while (stage.size() > 0) begin
                stg_w = stage.pop_front();
                up_q[stg_w.ch].push_back(stg_w.data);
            end
            for (int i = 0; i < 4; i++) up_empty[i] <= (up_q[i].size() == 0);
        end
    end

    // Downstream model: counts writes when not draining and flags any write into a full FIFO.
    always @(posedge clk) begin
        if (ds_clr) begin
            ds_count <= 0;
        end else if (push && !ds_drain) begin
            if (ds_count >= 8) ds_ovf <= 1'b1;
            ds_count <= ds_count + 1;
        end
    end

    // Monitor: every downstream write is matched against the next expected word.
    always @(negedge clk) begin
        if (push === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_push: got ch %0d data 0x%0h, required no push (t=%0t)",
                         active_ch, data_out, $time);
            end else begin
                mon_w = sb.pop_front();
                check("push_data", 32'(data_out), 32'(mon_w.data));
                check("push_ch", 32'(active_ch), 32'(mon_w.ch));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ord3[4];
        ord3 = '{3, 0, 1, 2};

        // Reset state, with the first data set staged meanwhile.
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++) stage_word(c, 10'(32'h10 * (k + 1) + c));
        repeat (2) @(posedge clk);
        #2;
        check("rst_pop", 32'(pop), 32'h0);
        check("rst_push", 32'(push), 32'h0);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_ch", 32'(active_ch), 32'h0);
        check("rst_idle", 32'(idle), 32'h0);
        check("rst_error", 32'(error), 32'h0);

        // All four channels with two words: strict 0,1,2,3 rotation, then idle.
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++) expect_word(c, 10'(32'h10 * (k + 1) + c));
        reset = 1'b1;
        wait_drain("rotation", 40);
        check("idle_after_rotation", 32'(idle), 32'h1);

        // Only channel 2 holds words: five back-to-back pops and pushes, no underflow.
        for (int k = 0; k < 5; k++) begin
            stage_word(2, 10'(32'h50 + k));
            expect_word(2, 10'(32'h50 + k));
        end
        @(posedge clk);
        #2;
        for (int k = 0; k < 5; k++) begin
            check("ch2_pop", 32'(pop), 32'h4);
            if (k > 0) check("ch2_push", 32'(push), 32'h1);
            @(posedge clk);
            #2;
        end
        check("ch2_last_push", 32'(push), 32'h1);
        check("ch2_no_more_pop", 32'(pop), 32'h0);
        wait_drain("ch2", 20);
        check("ch2_no_underflow", 32'(up_err), 32'h0);
        check("ch2_error", 32'(error), 32'h0);

        // Downstream never read: stops at exactly 8 words with pop held low.
        ds_drain = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++) stage_word(c, 10'(32'h100 + 16 * c + k));
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 4; j++) expect_word(ord3[j], 10'(32'h100 + 16 * ord3[j] + k));
        wait_drain("fill", 40);
        for (int n = 0; n < 5; n++) begin
            check("full_pop_stalled", 32'(pop), 32'h0);
            @(posedge clk);
            #2;
        end
        check("full_count", 32'(ds_count), 32'd8);
        check("full_flag", 32'(out_full), 32'h1);
        check("full_no_overflow", 32'(ds_ovf), 32'h0);
        ds_drain = 1'b1;
        ds_clr = 1'b1;
        @(posedge clk);
        #2;
        ds_clr = 1'b0;
        for (int j = 0; j < 4; j++) expect_word(ord3[j], 10'(32'h100 + 16 * ord3[j] + 2));
        wait_drain("unstall", 40);

        // Three-cycle almost_full pulse mid-stream.
        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 2; c++) begin
                stage_word(c, 10'(32'h200 + 16 * c + k));
                expect_word(c, 10'(32'h200 + 16 * c + k));
            end
        @(posedge clk);
        #2;
        check("af_pre_pop", 32'(pop), 32'h1);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            af_force = 1'b1;
            #1;
            check("af_pop", 32'(pop), 32'h0);
            check("af_push", 32'(push), (n == 0) ? 32'h1 : 32'h0);
        end
        @(posedge clk);
        #1;
        af_force = 1'b0;
        #1;
        check("af_resume_pop", 32'(pop), 32'h2);
        check("af_resume_push", 32'(push), 32'h0);
        wait_drain("af", 40);

        // Upstream error: pop cut at once, in-flight word completes, error sticks.
        for (int k = 0; k < 4; k++) stage_word(3, 10'(32'h380 + k));
        expect_word(3, 10'h380);
        @(posedge clk);
        #2;
        check("err_pre_pop", 32'(pop), 32'h8);
        @(posedge clk);
        #1;
        err_force = 4'b0010;
        #1;
        check("err_pop_now", 32'(pop), 32'h0);
        check("err_inflight_push", 32'(push), 32'h1);
        check("err_not_yet", 32'(error), 32'h0);
        @(posedge clk);
        #2;
        check("err_set", 32'(error), 32'h1);
        check("err_push_done", 32'(push), 32'h0);
        err_force = 4'b0000;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #2;
            check("err_sticky", 32'(error), 32'h1);
            check("err_pop_held", 32'(pop), 32'h0);
        end
        check("err_scoreboard", 32'(sb.size()), 32'h0);

        // Reset out of ERROR, then reset again while a push is on the output.
        reset = 1'b0;
        clr_req = 1'b1;
        @(posedge clk);
        #2;
        clr_req = 1'b0;
        check("rst2_error", 32'(error), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #2;
        stage_word(1, 10'h301);
        stage_word(1, 10'h311);
        expect_word(1, 10'h301);
        @(posedge clk);
        #2;
        check("mid_pop", 32'(pop), 32'h2);
        @(posedge clk);
        #2;
        check("mid_push", 32'(push), 32'h1);
        reset = 1'b0;
        @(posedge clk);
        #2;
        check("mid_rst_pop", 32'(pop), 32'h0);
        check("mid_rst_push", 32'(push), 32'h0);
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_ch", 32'(active_ch), 32'h0);
        check("mid_rst_idle", 32'(idle), 32'h0);
        check("mid_rst_error", 32'(error), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #2;
        for (int c = 0; c < 4; c++) begin
            stage_word(c, 10'(32'h400 + c));
            expect_word(c, 10'(32'h400 + c));
        end
        @(posedge clk);
        #2;
        check("post_rst_first_grant", 32'(pop), 32'h1);
        wait_drain("post_rst", 20);
        check("post_rst_idle", 32'(idle), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
